// File: rtl/lsu_mem_responder_if.sv
// LSU load/store request bus: one outstanding request, single-cycle response pulse.
interface lsu_mem_responder_if;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;

    modport master (
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata, lsu_resp_err
    );

    modport slave (
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata, lsu_resp_err
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Memory responder behind the LSU: byte-masked word RAM, UART TX register,
// and a configurable (optionally pseudo-random) response latency.
module lsu_mem_responder #(
    parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
    parameter int          RAM_WORDS  = 4096,
    parameter logic [31:0] UART_ADDR  = 32'h1000_0000,
    parameter int          LATENCY    = 2,
    parameter int          RAND_DELAY = 0
) (
    input  logic                clock,
    input  logic                reset,
    lsu_mem_responder_if.slave  bus,
    output logic                uart_tx_valid,
    output logic [7:0]          uart_tx_byte,
    output logic                busy
);
    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;
    localparam logic [31:0] DEV_BYTES = 32'h0000_1000;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {RSEL_ZERO, RSEL_RAM, RSEL_ERR} rsel_t;

    state_t      state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    rsel_t       rsel_q, rsel_d;
    logic        uart_valid_q, uart_valid_d;
    logic [7:0]  uart_byte_q, uart_byte_d;

    logic [31:0]      ram_off, dev_off, ram_rd;
    logic [IDX_W-1:0] ram_idx;
    logic             hit_ram, hit_dev, hit_uart, commit, ram_we, ram_re;
    logic [7:0]       uart_lane;

    // Region decode works on the latched address only.
    assign ram_off  = addr_q - RAM_BASE;
    assign dev_off  = addr_q - UART_ADDR;
    assign hit_ram  = ram_off < RAM_BYTES;
    assign hit_dev  = dev_off < DEV_BYTES;
    assign hit_uart = addr_q == UART_ADDR;
    assign ram_idx  = ram_off[IDX_W+1:2];
    assign commit   = (state_q == S_WAIT) && (counter_q == 5'd0);
    assign ram_we   = commit && wen_q && hit_ram && !reset;
    assign ram_re   = commit && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            counter_q     <= 5'd0;
            lfsr_q        <= 8'hA5;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            rsel_q        <= RSEL_ZERO;
            uart_valid_q  <= 1'b0;
            uart_byte_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            lfsr_q        <= lfsr_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            rsel_q        <= rsel_d;
            uart_valid_q  <= uart_valid_d;
            uart_byte_q   <= uart_byte_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        wen_q   <= wen_d;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        lfsr_d    = lfsr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wen_d     = wen_q;
        case (state_q)
            S_IDLE: begin
                if (bus.lsu_reqValid) begin
                    addr_d    = bus.lsu_addr;
                    wdata_d   = bus.lsu_wdata;
                    wmask_d   = bus.lsu_wmask;
                    wen_d     = bus.lsu_wen;
                    counter_d = 5'(LATENCY) + ((RAND_DELAY != 0) ? {3'b000, lfsr_q[1:0]} : 5'd0);
                    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (counter_q == 5'd0) state_d = S_RESP;
                else                   counter_d = counter_q - 5'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // UART takes the lane of the lowest enabled byte, lane 0 when no byte is enabled.
    always_comb begin
        uart_lane = wdata_q[7:0];
        for (int i = 3; i >= 0; i--) begin
            if (wmask_q[i]) uart_lane = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        resp_valid_d = commit;
        resp_err_d   = commit && !hit_ram && !hit_dev;
        uart_valid_d = commit && wen_q && hit_uart;
        uart_byte_d  = (commit && wen_q && hit_uart) ? uart_lane : uart_byte_q;
        rsel_d       = rsel_q;
        if (commit) begin
            if (hit_ram)      rsel_d = RSEL_RAM;
            else if (hit_dev) rsel_d = RSEL_ZERO;
            else              rsel_d = RSEL_ERR;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [RAM_WORDS];
            logic [7:0] rd_q;
            always_ff @(posedge clock) begin
                if (ram_we && wmask_q[gi]) mem[ram_idx] <= wdata_q[8*gi +: 8];
                if (ram_re)                rd_q         <= mem[ram_idx];
            end
            assign ram_rd[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_comb begin
        case (rsel_q)
            RSEL_RAM: bus.lsu_rdata = ram_rd;
            RSEL_ERR: bus.lsu_rdata = 32'hDEAD_BEEF;
            default:  bus.lsu_rdata = 32'h0000_0000;
        endcase
    end

    assign bus.lsu_respValid = resp_valid_q;
    assign bus.lsu_resp_err  = resp_err_q;
    assign uart_tx_valid     = uart_valid_q;
    assign uart_tx_byte      = uart_byte_q;
    assign busy              = state_q != S_IDLE;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: directed checks on a fixed-latency instance and
// randomized traffic against an array model on a random-latency instance.
module tb_lsu_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_responder_if bus0();
    lsu_mem_responder_if bus1();
    logic       uv0, uv1, busy0, busy1;
    logic [7:0] ub0, ub1;

    lsu_mem_responder #(.LATENCY(2), .RAND_DELAY(0)) dut0 (
        .clock(clk), .reset(rst), .bus(bus0),
        .uart_tx_valid(uv0), .uart_tx_byte(ub0), .busy(busy0)
    );

    lsu_mem_responder #(.RAM_WORDS(64), .LATENCY(2), .RAND_DELAY(1)) dut1 (
        .clock(clk), .reset(rst), .bus(bus1),
        .uart_tx_valid(uv1), .uart_tx_byte(ub1), .busy(busy1)
    );

    int tests = 0;
    int fails = 0;
    int resp1_cnt = 0;
    int uart0_cnt = 0;
    always @(posedge clk) begin
        if (bus1.lsu_respValid === 1'b1) resp1_cnt++;
        if (uv0 === 1'b1) uart0_cnt++;
    end

    task automatic set_req(input int sel, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        if (sel == 0) begin
            bus0.lsu_reqValid = v; bus0.lsu_wen = w; bus0.lsu_addr = a;
            bus0.lsu_wdata = d; bus0.lsu_wmask = m; bus0.lsu_size = 2'b10;
        end else begin
            bus1.lsu_reqValid = v; bus1.lsu_wen = w; bus1.lsu_addr = a;
            bus1.lsu_wdata = d; bus1.lsu_wmask = m; bus1.lsu_size = 2'b10;
        end
    endtask

    // LSU-side driver: hold the request until respValid, drop it, then wait out the RESP cycle.
    task automatic do_req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit scramble,
                          output logic [31:0] rd, output logic er, output logic uvv,
                          output logic [7:0] ubb, output int lat);
        bit seen;
        logic rv;
        seen = 0; lat = 0; rd = '0; er = 0; uvv = 0; ubb = '0;
        set_req(sel, 1'b1, w, a, d, m);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (scramble && c == 1)
                set_req(sel, 1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
            rv = (sel == 0) ? bus0.lsu_respValid : bus1.lsu_respValid;
            if (rv === 1'b1) begin
                seen = 1; lat = c;
                rd  = (sel == 0) ? bus0.lsu_rdata    : bus1.lsu_rdata;
                er  = (sel == 0) ? bus0.lsu_resp_err : bus1.lsu_resp_err;
                uvv = (sel == 0) ? uv0 : uv1;
                ubb = (sel == 0) ? ub0 : ub1;
            end
        end
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (!seen) begin
            tests++; fails++;
            $display("FAIL resp_timeout sel=%0d addr=%h: got no respValid, required one within 40 cycles", sel, a);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        tests += 6;
        if (bus0.lsu_respValid !== 1'b0) begin fails++; $display("FAIL reset_respValid got=%b want=0", bus0.lsu_respValid); end
        if (bus0.lsu_resp_err !== 1'b0)  begin fails++; $display("FAIL reset_err got=%b want=0", bus0.lsu_resp_err); end
        if (bus0.lsu_rdata !== 32'h0)    begin fails++; $display("FAIL reset_rdata got=%h want=0", bus0.lsu_rdata); end
        if (uv0 !== 1'b0)                begin fails++; $display("FAIL reset_uart_valid got=%b want=0", uv0); end
        if (ub0 !== 8'h00)               begin fails++; $display("FAIL reset_uart_byte got=%h want=00", ub0); end
        if (busy0 !== 1'b0)              begin fails++; $display("FAIL reset_busy got=%b want=0", busy0); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, uvv; logic [7:0] ubb; int lat;
        do_req(0, 1'b1, 32'h8000_0010, 32'hCAFE_BABE, 4'hF, 0, rd, er, uvv, ubb, lat);
        $display("[TB] store 80000010 CAFEBABE lat=%0d err=%b", lat, er);
        tests += 2;
        if (lat != 4)   begin fails++; $display("FAIL store_latency got=%0d want=4", lat); end
        if (er !== 1'b0) begin fails++; $display("FAIL store_err got=%b want=0", er); end
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] load 80000010 -> %h lat=%0d err=%b", rd, lat, er);
        tests += 3;
        if (rd !== 32'hCAFE_BABE) begin fails++; $display("FAIL load_data got=%h want=cafebabe", rd); end
        if (lat != 4)    begin fails++; $display("FAIL load_latency got=%0d want=4", lat); end
        if (er !== 1'b0) begin fails++; $display("FAIL load_err got=%b want=0", er); end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er, uvv; logic [7:0] ubb; int lat;
        do_req(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 0, rd, er, uvv, ubb, lat);
        do_req(0, 1'b1, 32'h8000_0012, 32'h00AB_0000, 4'b0100, 0, rd, er, uvv, ubb, lat);
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] byte store lane2 AB, load 80000010 -> %h", rd);
        tests++;
        if (rd !== 32'h11AB_3344) begin fails++; $display("FAIL byte_store got=%h want=11ab3344", rd); end
        do_req(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er, uvv, ubb, lat);
        do_req(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] mask0 store then unaligned load 80000013 -> %h err=%b", rd, er);
        tests += 2;
        if (rd !== 32'h11AB_3344) begin fails++; $display("FAIL mask0_noop got=%h want=11ab3344", rd); end
        if (er !== 1'b0) begin fails++; $display("FAIL unaligned_err got=%b want=0", er); end
    endtask

    task automatic test_uart();
        logic [31:0] rd; logic er, uvv; logic [7:0] ubb; int lat, n0;
        n0 = uart0_cnt;
        do_req(0, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001, 0, rd, er, uvv, ubb, lat);
        $display("[TB] uart store 41 -> valid=%b byte=%h err=%b", uvv, ubb, er);
        tests += 4;
        if (uvv !== 1'b1)    begin fails++; $display("FAIL uart_valid got=%b want=1", uvv); end
        if (ubb !== 8'h41)   begin fails++; $display("FAIL uart_byte got=%h want=41", ubb); end
        if (er !== 1'b0)     begin fails++; $display("FAIL uart_err got=%b want=0", er); end
        if (uart0_cnt - n0 != 1) begin fails++; $display("FAIL uart_pulses got=%0d want=1", uart0_cnt - n0); end
        do_req(0, 1'b1, 32'h1000_0000, 32'h1234_4200, 4'b0110, 0, rd, er, uvv, ubb, lat);
        $display("[TB] uart store mask 0110 -> valid=%b byte=%h", uvv, ubb);
        tests++;
        if (ubb !== 8'h42) begin fails++; $display("FAIL uart_low_lane got=%h want=42", ubb); end
        do_req(0, 1'b1, 32'h1000_0004, 32'h0000_0055, 4'b0001, 0, rd, er, uvv, ubb, lat);
        $display("[TB] device store 10000004 -> valid=%b err=%b", uvv, er);
        tests += 2;
        if (uvv !== 1'b0) begin fails++; $display("FAIL dev_other_uart got=%b want=0", uvv); end
        if (er !== 1'b0)  begin fails++; $display("FAIL dev_other_err got=%b want=0", er); end
        do_req(0, 1'b0, 32'h1000_0FFC, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] device load 10000ffc -> %h err=%b", rd, er);
        tests += 2;
        if (rd !== 32'h0) begin fails++; $display("FAIL dev_load got=%h want=0", rd); end
        if (er !== 1'b0)  begin fails++; $display("FAIL dev_load_err got=%b want=0", er); end
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] load 80000010 after uart -> %h", rd);
        tests++;
        if (rd !== 32'h11AB_3344) begin fails++; $display("FAIL uart_ram_untouched got=%h want=11ab3344", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic er, uvv; logic [7:0] ubb; int lat;
        logic [31:0] bad [4];
        bad[0] = 32'h0000_0000; bad[1] = 32'h8000_4000; bad[2] = 32'h0FFF_FFFC; bad[3] = 32'h1000_1000;
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, bad[i], 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
            $display("[TB] unmapped load %h -> %h err=%b", bad[i], rd, er);
            tests += 3;
            if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL unmapped_data addr=%h got=%h want=deadbeef", bad[i], rd); end
            if (er !== 1'b1) begin fails++; $display("FAIL unmapped_err addr=%h got=%b want=1", bad[i], er); end
            if (bus0.lsu_resp_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got=%b want=0", bus0.lsu_resp_err); end
        end
        do_req(0, 1'b1, 32'h0000_0000, 32'h5555_5555, 4'hF, 0, rd, er, uvv, ubb, lat);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL unmapped_store_err got=%b want=1", er); end
        do_req(0, 1'b1, 32'h8000_4000, 32'h6666_6666, 4'hF, 0, rd, er, uvv, ubb, lat);
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] load 80000010 after unmapped stores -> %h", rd);
        tests++;
        if (rd !== 32'h11AB_3344) begin fails++; $display("FAIL unmapped_store_dropped got=%h want=11ab3344", rd); end
        do_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        tests++;
        if (rd !== 32'h6666_6666 && rd !== 32'h5555_5555) begin end
        else begin fails++; $display("FAIL unmapped_alias got=%h want=neither 55555555 nor 66666666", rd); end
        do_req(0, 1'b1, 32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 0, rd, er, uvv, ubb, lat);
        do_req(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] last RAM word 80003ffc -> %h err=%b", rd, er);
        tests += 2;
        if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL last_word got=%h want=0badf00d", rd); end
        if (er !== 1'b0) begin fails++; $display("FAIL last_word_err got=%b want=0", er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, uvv; logic [7:0] ubb; int lat;
        bit stray;
        do_req(0, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 0, rd, er, uvv, ubb, lat);
        set_req(0, 1'b1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        tests++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL busy_in_wait got=%b want=1", busy0); end
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tests += 2;
        if (busy0 !== 1'b0) begin fails++; $display("FAIL busy_after_reset got=%b want=0", busy0); end
        if (bus0.lsu_respValid !== 1'b0) begin fails++; $display("FAIL resp_at_reset got=%b want=0", bus0.lsu_respValid); end
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus0.lsu_respValid !== 1'b0) stray = 1;
        end
        tests++;
        if (stray) begin fails++; $display("FAIL resp_after_reset got=1 want=0"); end
        do_req(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, uvv, ubb, lat);
        $display("[TB] reset mid-store, load 80000020 -> %h busy=%b", rd, busy0);
        tests += 2;
        if (rd !== 32'h1111_1111) begin fails++; $display("FAIL aborted_store got=%h want=11111111", rd); end
        if (busy0 !== 1'b0) begin fails++; $display("FAIL busy_idle got=%b want=0", busy0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [64];
        logic [31:0] rd, a, d; logic er, uvv, w; logic [7:0] ubb; logic [3:0] m;
        int lat, dly, min_d, max_d, idx, n0, nreq;
        n0 = resp1_cnt; nreq = 0; min_d = 99; max_d = -1;
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            do_req(1, 1'b1, 32'h8000_0000 + 32'(i * 4), model[i], 4'hF, 1, rd, er, uvv, ubb, lat);
            nreq++;
        end
        for (int t = 0; t < 200; t++) begin
            idx = int'($urandom_range(63));
            a = 32'h8000_0000 + 32'(idx * 4) + 32'($urandom_range(3));
            w = 1'($urandom); d = $urandom; m = 4'($urandom);
            do_req(1, w, a, d, m, 1, rd, er, uvv, ubb, lat);
            nreq++;
            dly = lat - 2;
            if (dly < min_d) min_d = dly;
            if (dly > max_d) max_d = dly;
            tests++;
            if (dly < 2 || dly > 5) begin fails++; $display("FAIL rand_latency t=%0d got=%0d want=2..5", t, dly); end
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                $display("[TB] rnd %0d st %h d=%h m=%b lat=%0d", t, a, d, m, dly);
            end else begin
                $display("[TB] rnd %0d ld %h -> %h exp %h lat=%0d", t, a, rd, model[idx], dly);
                tests++;
                if (rd !== model[idx] || er !== 1'b0) begin
                    fails++; $display("FAIL rand_load t=%0d addr=%h got=%h err=%b want=%h err=0", t, a, rd, er, model[idx]);
                end
            end
        end
        tests += 3;
        if (min_d != 2) begin fails++; $display("FAIL latency_min got=%0d want=2", min_d); end
        if (max_d != 5) begin fails++; $display("FAIL latency_max got=%0d want=5", max_d); end
        if (resp1_cnt - n0 != nreq) begin fails++; $display("FAIL resp_count got=%0d want=%0d", resp1_cnt - n0, nreq); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_uart();
        test_unmapped();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
